r_pkt_tx: RTL and testbench
===========================

Name: r_pkt_tx

Overview:
Packet transmitter that drives the input side of the 1x4 router (data_in / pkt_valid / busy).
- Accepts a packet request (destination port, payload length) plus a byte stream of payload from an upstream source.
- Buffers the whole payload internally and computes parity, then emits header, payload and parity back-to-back, stalling on router busy.
- Sits between stimulus/host logic and the router top, one instance per router.

Parameters:
MAX_LEN, 63, maximum payload length in bytes; sets the buffer depth (6-bit length field).
GAP_CYCLES, 2, minimum idle cycles with pkt_valid low after the parity byte before the next header.

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
req_valid  input  1  packet request valid
req_addr  input  2  destination port 0..3
req_len  input  6  payload length 1..63
req_corrupt  input  1  invert parity bit 0 of this packet (error injection)
req_ready  output  1  request accepted when req_valid & req_ready
pl_data  input  8  payload byte
pl_valid  input  1  payload byte valid
pl_ready  output  1  payload byte accepted when pl_valid & pl_ready
busy  input  1  router busy; transmitter holds its output while high
data_in  output  8  byte to router (header/payload/parity)
pkt_valid  output  1  high during header and payload bytes, low during parity
tx_done  output  1  one-cycle pulse when the parity byte is consumed
len_drop  output  1  one-cycle pulse when a req_len==0 request is discarded
pkt_count  output  16  packets completed since reset, wraps at 16'hFFFF->0

Behaviour:
- Reset (resetn==0 at rising edge): state=IDLE; data_in=0, pkt_valid=0, req_ready=0, pl_ready=0, tx_done=0, len_drop=0, pkt_count=0. Buffer pointers, parity accumulator and gap counter are cleared. Reset mid-packet abandons the packet; no trailing parity is sent.
- States: IDLE, LOAD, HDR, PLD, PAR, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid with req_len!=0: latch addr, len and corrupt; parity_acc=0; write pointer=0; go to LOAD.
  - On req_valid with req_len==0: pulse len_drop and stay in IDLE.
- LOAD:
  - pl_ready=1 while write pointer < len.
  - Each accepted byte is written to the buffer, write pointer++, parity_acc ^= byte.
  - When the last byte is accepted, the next state is HDR.
  - pl_ready=0 in all other states.
- Output register: data_in/pkt_valid are registered. A byte is "consumed" at a rising edge where the state is HDR/PLD/PAR and busy==0. While busy==1, data_in, pkt_valid and the state hold unchanged.
- HDR: data_in={len,addr}, pkt_valid=1. On consume, parity_acc ^= header; go to PLD with read pointer=0.
- PLD: data_in=buf[rd], pkt_valid=1. On consume, rd++. After byte len-1 is consumed, go to PAR. No bubble is permitted between header and payload or between payload bytes.
- PAR: data_in = parity_acc ^ {7'b0, corrupt}, pkt_valid=0. On consume: tx_done=1 for one cycle, pkt_count++, go to GAP.
- GAP: pkt_valid=0, data_in=0 for GAP_CYCLES cycles, then IDLE. busy is ignored.
- Parity is the XOR of the header and all payload bytes.
- First header appears 1 cycle after the last payload byte is accepted.
- Simultaneous events:
  - busy rising in the same cycle as a state transition: the transition already clocked stands; the hold applies from the next edge.
  - req_valid outside IDLE is ignored (req_ready=0).

Test Plan:
- Basic packet: addr=2, len=3, payload AA,55,0F, busy=0 -> data_in sequence 0E(pv=1), AA, 55, 0F (pv=1), FE (pv=0); tx_done pulses on the parity edge; pkt_count=1.
- Busy stall: same packet, busy=1 for 3 cycles while 55 is on data_in -> 55 held with pkt_valid=1 for 4 cycles, no byte skipped or repeated, parity still FE.
- Corrupt + max length: addr=3, len=63, bytes 00..3E, req_corrupt=1 -> header FF, 63 payload bytes in order, parity = (FF^XOR(00..3E)) ^ 01; router err asserts.
- Zero length: req_len=0 -> len_drop=1 for one cycle, state stays IDLE, pkt_valid never asserts.
- Reset mid-packet: resetn=0 while the 2nd payload byte is on data_in -> next cycle pkt_valid=0, data_in=00, req_ready=0. Release reset -> req_ready=1, and a new packet transmits correctly with pkt_count=1.
- Back-to-back: two queued requests -> at least GAP_CYCLES=2 cycles of pkt_valid=0 between the first parity byte and the second header; pkt_count=2.

Source files
------------

// File: rtl/r_pkt_tx.sv
// r_pkt_tx: packet transmitter feeding the 1x4 router input.
// It buffers a whole payload and accumulates parity while loading.
// It then sends the header, the payload and the parity byte back-to-back.
// A busy signal from the router holds the output.
// There is an idle gap after each packet.
//
// state  | meaning
// IDLE   | ready for a request; zero-length requests are dropped here
// LOAD   | accepting payload bytes into the buffer
// HDR    | header {len, addr} on data_in
// PLD    | payload byte buf[rd-1] on data_in
// PAR    | parity byte on data_in, pkt_valid low
// GAP    | forced idle after the parity byte
module r_pkt_tx #(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [1:0]  req_addr,
    input  logic [5:0]  req_len,
    input  logic        req_corrupt,
    output logic        req_ready,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic        busy,
    output logic [7:0]  data_in,
    output logic        pkt_valid,
    output logic        tx_done,
    output logic        len_drop,
    output logic [15:0] pkt_count
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_PLD  = 3'd3;
    localparam logic [2:0] S_PAR  = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    logic [2:0]       state;
    logic [1:0]       addr_q;
    logic [5:0]       len_q;
    logic             corrupt_q;
    logic [5:0]       wr_ptr;
    logic [5:0]       rd_ptr;
    logic [7:0]       parity_acc;
    logic [GAP_W-1:0] gap_cnt;
    logic [7:0]       pkt_buf [0:MAX_LEN-1];

    logic       req_fire;
    logic       pl_fire;
    logic [7:0] hdr_byte;

    // req_ready is only ever high in IDLE, so a fire implies IDLE.
    assign req_fire = req_valid && req_ready;
    assign pl_ready = (state == S_LOAD) && (wr_ptr < len_q);
    assign pl_fire  = pl_valid && pl_ready;
    assign hdr_byte = {len_q, addr_q};

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (pl_fire) begin
            pkt_buf[wr_ptr] <= pl_data;
        end
    end

    // Sequencer, output register and counters.
    // rd_ptr always points one past the payload byte currently shown.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            data_in    <= 8'h00;
            pkt_valid  <= 1'b0;
            req_ready  <= 1'b0;
            tx_done    <= 1'b0;
            len_drop   <= 1'b0;
            pkt_count  <= 16'h0000;
            addr_q     <= 2'd0;
            len_q      <= 6'd0;
            corrupt_q  <= 1'b0;
            wr_ptr     <= 6'd0;
            rd_ptr     <= 6'd0;
            parity_acc <= 8'h00;
            gap_cnt    <= '0;
        end else begin
            tx_done  <= 1'b0;
            len_drop <= 1'b0;
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_fire) begin
                        if (req_len != 6'd0) begin
                            addr_q     <= req_addr;
                            len_q      <= req_len;
                            corrupt_q  <= req_corrupt;
                            parity_acc <= 8'h00;
                            wr_ptr     <= 6'd0;
                            req_ready  <= 1'b0;
                            state      <= S_LOAD;
                        end else begin
                            len_drop <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (pl_fire) begin
                        wr_ptr     <= wr_ptr + 6'd1;
                        parity_acc <= parity_acc ^ pl_data;
                        if (wr_ptr == len_q - 6'd1) begin
                            data_in   <= hdr_byte;
                            pkt_valid <= 1'b1;
                            state     <= S_HDR;
                        end
                    end
                end
                S_HDR: begin
                    if (!busy) begin
                        parity_acc <= parity_acc ^ hdr_byte;
                        data_in    <= pkt_buf[0];
                        rd_ptr     <= 6'd1;
                        state      <= S_PLD;
                    end
                end
                S_PLD: begin
                    if (!busy) begin
                        if (rd_ptr == len_q) begin
                            data_in   <= parity_acc ^ {7'b0, corrupt_q};
                            pkt_valid <= 1'b0;
                            state     <= S_PAR;
                        end else begin
                            data_in <= pkt_buf[rd_ptr];
                            rd_ptr  <= rd_ptr + 6'd1;
                        end
                    end
                end
                S_PAR: begin
                    if (!busy) begin
                        tx_done   <= 1'b1;
                        pkt_count <= pkt_count + 16'd1;
                        data_in   <= 8'h00;
                        gap_cnt   <= GAP_W'(GAP_CYCLES - 1);
                        state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    req_ready <= 1'b0;
                    pkt_valid <= 1'b0;
                    data_in   <= 8'h00;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r_pkt_tx.sv
// Testbench for r_pkt_tx.
// Directed vector table plus randomized packets.
// Expected byte streams come from a packet-level model:
// header {len,addr}, the payload, and the XOR of all of them.
module tb_r_pkt_tx;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [1:0]  req_addr;
    logic [5:0]  req_len;
    logic        req_corrupt;
    logic        req_ready;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_ready;
    logic        busy;
    logic [7:0]  data_in;
    logic        pkt_valid;
    logic        tx_done;
    logic        len_drop;
    logic [15:0] pkt_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    logic [7:0] pay [0:63];

    typedef struct {
        logic [1:0]  addr;
        logic [5:0]  len;
        logic        corrupt;
        logic [23:0] b3;
        logic        incr;
        int          stall_idx;
        int          stall_len;
        logic [7:0]  hdr;
        logic [7:0]  par;
    } vec_t;

    vec_t tab [5];

    always #5 clk = ~clk;

    r_pkt_tx dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_corrupt(req_corrupt),
        .req_ready  (req_ready),
        .pl_data    (pl_data),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .busy       (busy),
        .data_in    (data_in),
        .pkt_valid  (pkt_valid),
        .tx_done    (tx_done),
        .len_drop   (len_drop),
        .pkt_count  (pkt_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    // Send one packet from pay[] and check everything the router would see.
    // abort_idx >= 0 pulls reset while stream byte abort_idx is on data_in.
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic c,
                            input logic use_tab, input logic [7:0] t_hdr, input logic [7:0] t_par,
                            input int stall_idx, input int stall_len, input int busy_pct,
                            input int abort_idx);
        logic [7:0] exp_s [0:65];
        logic [7:0] par;
        logic [7:0] d, prev_d;
        logic       pv, prev_pv, prev_busy, b, rdy, v;
        int         n, idx, stall_left, hold_cnt;

        exp_s[0] = {l, a};
        par = {l, a};
        for (int i = 0; i < int'(l); i++) begin
            exp_s[i+1] = pay[i];
            par ^= pay[i];
        end
        exp_s[l+1] = par ^ {7'b0, c};
        if (use_tab) begin
            exp_s[0]   = t_hdr;
            exp_s[l+1] = t_par;
        end

        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            timeout("req_ready wait");
            return;
        end
        req_valid = 1'b1; req_addr = a; req_len = l; req_corrupt = c;
        @(negedge clk);
        req_valid = 1'b0;
        check("req_ready after accept", req_ready, 0);

        idx = 0; n = 0;
        while (idx < int'(l) && n < 1000) begin
            rdy = pl_ready;
            v = ($urandom_range(3) != 0);
            pl_valid = v;
            pl_data = pay[idx];
            @(negedge clk);
            n++;
            if (v && rdy) idx++;
        end
        pl_valid = 1'b0;
        if (idx < int'(l)) begin
            timeout("payload load");
            return;
        end

        check("pl_ready low after load", pl_ready, 0);
        idx = 0; n = 0; stall_left = stall_len; hold_cnt = 0;
        prev_busy = 1'b0; prev_d = 8'h00; prev_pv = 1'b0;
        while (idx < int'(l) + 2 && n < 2000) begin
            d = data_in;
            pv = pkt_valid;
            if (prev_busy) begin
                check("hold data", d, prev_d);
                check("hold pkt_valid", pv, prev_pv);
            end
            if (idx == abort_idx) begin
                check("byte before abort", d, exp_s[idx]);
                resetn = 1'b0;
                busy = 1'b0;
                @(negedge clk);
                check("abort pkt_valid", pkt_valid, 0);
                check("abort data_in", data_in, 0);
                check("abort req_ready", req_ready, 0);
                check("abort pl_ready", pl_ready, 0);
                check("abort tx_done", tx_done, 0);
                check("abort pkt_count", pkt_count, 0);
                resetn = 1'b1;
                exp_cnt = 0;
                return;
            end
            if (idx == stall_idx) hold_cnt++;
            if (idx == stall_idx && stall_left > 0) begin
                b = 1'b1;
                stall_left--;
            end else begin
                b = ($urandom_range(99) < busy_pct);
            end
            busy = b;
            if (!b) begin
                check("stream byte", d, exp_s[idx]);
                check("stream pkt_valid", pv, (idx <= int'(l)));
                idx++;
            end
            prev_busy = b; prev_d = d; prev_pv = pv;
            @(negedge clk);
            n++;
        end
        busy = 1'b0;
        if (idx < int'(l) + 2) begin
            timeout("packet transmit");
            return;
        end
        if (stall_len > 0) check("stall hold cycles", hold_cnt, stall_len + 1);

        exp_cnt++;
        check("tx_done pulse", tx_done, 1);
        check("pkt_count", pkt_count, exp_cnt[15:0]);
        check("gap1 pkt_valid", pkt_valid, 0);
        check("gap1 data_in", data_in, 0);
        check("gap1 req_ready", req_ready, 0);
        @(negedge clk);
        check("tx_done single", tx_done, 0);
        check("gap2 pkt_valid", pkt_valid, 0);
        check("gap2 req_ready", req_ready, 0);
        @(negedge clk);
        check("idle req_ready", req_ready, 1);
        check("idle pkt_valid", pkt_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] b3;
        logic [1:0]  ra;
        logic [5:0]  rl;

        tab[0] = '{2'd2, 6'd3,  1'b0, 24'hAA550F, 1'b0, -1, 0, 8'h0E, 8'hFE};
        tab[1] = '{2'd2, 6'd3,  1'b0, 24'hAA550F, 1'b0,  2, 3, 8'h0E, 8'hFE};
        tab[2] = '{2'd3, 6'd63, 1'b1, 24'h000000, 1'b1, -1, 0, 8'hFF, 8'hC1};
        tab[3] = '{2'd0, 6'd1,  1'b0, 24'h5A0000, 1'b0, -1, 0, 8'h04, 8'h5E};
        tab[4] = '{2'd1, 6'd2,  1'b1, 24'h00FF00, 1'b0,  0, 2, 8'h09, 8'hF7};

        resetn = 1'b0; req_valid = 1'b0; req_addr = 2'd0; req_len = 6'd0;
        req_corrupt = 1'b0; pl_data = 8'h00; pl_valid = 1'b0; busy = 1'b0;
        repeat (3) @(negedge clk);
        check("reset data_in", data_in, 0);
        check("reset pkt_valid", pkt_valid, 0);
        check("reset req_ready", req_ready, 0);
        check("reset pl_ready", pl_ready, 0);
        check("reset tx_done", tx_done, 0);
        check("reset len_drop", len_drop, 0);
        check("reset pkt_count", pkt_count, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("req_ready after reset", req_ready, 1);

        // Reset while the 2nd payload byte is on data_in.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        send_pkt(2'd1, 6'd4, 1'b0, 1'b0, 8'h00, 8'h00, -1, 0, 0, 2);
        @(negedge clk);
        check("req_ready after abort release", req_ready, 1);

        // Directed table; entry 0 is the first packet after the abort.
        for (int k = 0; k < 5; k++) begin
            b3 = tab[k].b3;
            for (int i = 0; i < 64; i++) pay[i] = tab[k].incr ? 8'(i) : 8'h00;
            if (!tab[k].incr) begin
                pay[0] = b3[23:16]; pay[1] = b3[15:8]; pay[2] = b3[7:0];
            end
            send_pkt(tab[k].addr, tab[k].len, tab[k].corrupt, 1'b1, tab[k].hdr, tab[k].par,
                     tab[k].stall_idx, tab[k].stall_len, 0, -1);
        end

        // Zero-length request is dropped.
        req_valid = 1'b1; req_addr = 2'd1; req_len = 6'd0; req_corrupt = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("len_drop pulse", len_drop, 1);
        check("len_drop req_ready", req_ready, 1);
        check("len_drop pkt_valid", pkt_valid, 0);
        check("len_drop pl_ready", pl_ready, 0);
        @(negedge clk);
        check("len_drop single", len_drop, 0);
        check("len_drop still idle", pkt_valid, 0);

        // Back-to-back: the second request is presented as soon as IDLE returns.
        pay[0] = 8'hC3; pay[1] = 8'h3C;
        send_pkt(2'd0, 6'd2, 1'b0, 1'b0, 8'h00, 8'h00, -1, 0, 0, -1);
        pay[0] = 8'h81;
        send_pkt(2'd3, 6'd1, 1'b1, 1'b0, 8'h00, 8'h00, -1, 0, 0, -1);

        // Randomized packets with random router back-pressure.
        for (int k = 0; k < 20; k++) begin
            ra = 2'($urandom_range(3));
            case (k % 5)
                0: rl = 6'd1;
                1: rl = 6'd63;
                default: rl = 6'($urandom_range(63, 1));
            endcase
            for (int i = 0; i < 64; i++) pay[i] = 8'($urandom_range(255));
            send_pkt(ra, rl, 1'($urandom_range(1)), 1'b0, 8'h00, 8'h00, -1, 0, 30, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
